dsp_addsub: RTL and testbench
=============================

Name: dsp_addsub

Overview:
- Registered 32-bit dual adder/subtractor for the ALU datapath, structured to map onto the FPGA DSP carry chain.
- Computes A+B and A−B on the same operands in parallel.
- Presents both results together with carry, borrow and overflow flags one clock later.
- The ALU result mux selects between the sum and difference outputs; it never instantiates a separate adder and subtractor.

Parameters:
- WIDTH, 32, operand and result width; must be even and ≥ 2; the datapath splits into two WIDTH/2 slices.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands on a_in/b_in are valid this cycle.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- sum  out  WIDTH  registered (A+B) mod 2^WIDTH.
- sub  out  WIDTH  registered (A−B) mod 2^WIDTH.
- carry_out  out  1  unsigned carry out of A+B.
- borrow_out  out  1  1 when A < B unsigned.
- add_ovf  out  1  signed overflow of A+B.
- sub_ovf  out  1  signed overflow of A−B.
- out_valid  out  1  outputs hold a fresh result.

Behaviour:
- Reset: when reset=1 at a rising edge, every output becomes 0. Reset has priority over in_valid. Reset asserted mid-stream discards the in-flight result.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, the results for those operands appear after edge N, and out_valid=1 for that cycle.
- Throughput: one operation per cycle, back-to-back; no stall or ready signal.
- Idle cycles: when in_valid=0 at an edge, out_valid goes 0 and sum/sub/flags hold their previous values (no X, no recompute).
- Add path: {carry_out, sum} = a_in + b_in, zero-extended to WIDTH+1 bits.
- Subtract path: sub = a_in + ~b_in + 1.
  - borrow_out = NOT(carry of that addition).
  - B=0 therefore gives borrow_out=0.
- Overflow flags:
  - add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - sub_ovf = (a[MSB] != b[MSB]) && (sub[MSB] != a[MSB]).
- Slice structure: each path is two WIDTH/2 slices.
  - The low slice takes carry-in 0 for add and 1 for subtract.
  - The high slice takes the low slice's carry-out combinationally in the same cycle; there is no extra pipeline stage between slices.
- Wrap-around: results are modulo 2^WIDTH, with no saturation.
- Outputs are driven only from flops. There is no combinational path from the inputs to any output.
- No initial blocks; reset is the only initialisation mechanism.

Decomposition:
- Shared package: WIDTH default constant (32) and the slice-width derivation (WIDTH/2). No typedefs needed.
- Sub-module dsp_addsub_slice: a combinational WIDTH/2 adder.
  - Ports: a, b, invert_b, cin; outputs s, cout.
  - Instantiated four times: add-low, add-high, sub-low, sub-high.
- Top level holds the output registers, the flag logic and the valid pipeline.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_valid=1, a=5, b=3. Required: all outputs 0 and out_valid=0 throughout; first edge after release yields sum=8, sub=2.
- Basic and cross-slice carry: a=0x0000FFFF, b=0x00000001.
  - Required: sum=0x00010000, sub=0x0000FFFE, carry_out=0, borrow_out=0, both ovf=0.
- Full wrap:
  - a=0xFFFFFFFF, b=1: sum=0, carry_out=1, sub=0xFFFFFFFE.
  - a=0, b=1: sub=0xFFFFFFFF, borrow_out=1, sub_ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=1: add_ovf=1, sum=0x80000000.
  - a=0x80000000, b=1: sub_ovf=1, sub=0x7FFFFFFF.
  - a=b=0x80000000: sum=0, carry_out=1, add_ovf=1, sub=0, sub_ovf=0, borrow_out=0.
- Pipelining and hold: feed (1,2),(10,3),(7,7) on consecutive cycles, then in_valid=0 for 2 cycles.
  - Required: sum=3,13,14 and sub=0xFFFFFFFF,7,0 on consecutive cycles with out_valid=1.
  - Then out_valid=0 and sum=14 held.
- Random: 10,000 random pairs compared against a reference model of +, −, and the flag equations, with reset pulsed at random mid-stream. Required: zero mismatches, and 0 outputs on the cycle after every reset.

Source files
------------

// File: rtl/dsp_addsub_pkg.sv
// dsp_addsub_pkg
//   Shared constants for the dual adder/subtractor.
//   WIDTH_DEFAULT : default operand/result width.
//   slice_width() : width of one carry-chain slice (half the datapath).
package dsp_addsub_pkg;

   localparam int WIDTH_DEFAULT = 32;

   // The datapath is split into two equal halves so each half maps onto
   // one DSP carry-chain segment; WIDTH must therefore be even and >= 2.
   function automatic int slice_width(input int width);
      return width / 2;
   endfunction

endpackage : dsp_addsub_pkg

// File: rtl/dsp_addsub_slice.sv
// dsp_addsub_slice
//   Purely combinational W-bit adder slice: s/cout = a + (b or ~b) + cin.
//   Ports:
//     a, b      in  W   operands
//     invert_b  in  1   1 = add ~b (subtract path), 0 = add b
//     cin       in  1   carry into bit 0
//     s         out W   slice result
//     cout      out 1   carry out of the top bit
module dsp_addsub_slice
   import dsp_addsub_pkg::*;
#(
   parameter int W = slice_width(WIDTH_DEFAULT)
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         invert_b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W-1:0] b_eff;
   logic [W:0]   total;

   always_comb begin
      b_eff = invert_b ? ~b : b;
      // One extra bit on every term so the carry out lands in total[W].
      total = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
   end

   assign s    = total[W-1:0];
   assign cout = total[W];

endmodule : dsp_addsub_slice

// File: rtl/dsp_addsub.sv
// dsp_addsub
//   Registered dual adder/subtractor. A+B and A-B are computed in parallel
//   on the same operands and presented, with flags, one clock later.
//   Ports:
//     clk        in  1      system clock (rising edge)
//     reset      in  1      synchronous active-high reset, all outputs -> 0
//     in_valid   in  1      a_in/b_in valid this cycle
//     a_in, b_in in  WIDTH  operands
//     sum        out WIDTH  (A+B) mod 2^WIDTH
//     sub        out WIDTH  (A-B) mod 2^WIDTH
//     carry_out  out 1      unsigned carry of A+B
//     borrow_out out 1      A < B unsigned
//     add_ovf    out 1      signed overflow of A+B
//     sub_ovf    out 1      signed overflow of A-B
//     out_valid  out 1      outputs hold a fresh result this cycle
//   When in_valid is low, the data and flag registers hold their values and
//   only out_valid drops.
module dsp_addsub
   import dsp_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] sub,
   output logic             carry_out,
   output logic             borrow_out,
   output logic             add_ovf,
   output logic             sub_ovf,
   output logic             out_valid
);

   localparam int HW  = slice_width(WIDTH);
   localparam int MSB = WIDTH - 1;

   // Index 0 = add path, index 1 = subtract path.
   logic [1:0][HW-1:0] lo_s;
   logic [1:0][HW-1:0] hi_s;
   logic [1:0]         lo_c;
   logic [1:0]         hi_c;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_path
         // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in
         // of the low slice.
         localparam logic IS_SUB = (gi == 1);

         dsp_addsub_slice #(.W(HW)) u_lo (
            .a        (a_in[HW-1:0]),
            .b        (b_in[HW-1:0]),
            .invert_b (IS_SUB),
            .cin      (IS_SUB),
            .s        (lo_s[gi]),
            .cout     (lo_c[gi])
         );

         // High slice chains directly off the low slice's carry in the same
         // cycle; no register between the halves.
         dsp_addsub_slice #(.W(HW)) u_hi (
            .a        (a_in[WIDTH-1:HW]),
            .b        (b_in[WIDTH-1:HW]),
            .invert_b (IS_SUB),
            .cin      (lo_c[gi]),
            .s        (hi_s[gi]),
            .cout     (hi_c[gi])
         );
      end
   endgenerate

   logic [WIDTH-1:0] add_full;
   logic [WIDTH-1:0] sub_full;

   logic [WIDTH-1:0] sum_d,    sum_q;
   logic [WIDTH-1:0] sub_d,    sub_q;
   logic             carry_d,  carry_q;
   logic             borrow_d, borrow_q;
   logic             add_ovf_d, add_ovf_q;
   logic             sub_ovf_d, sub_ovf_q;
   logic             valid_d,  valid_q;

   always_comb begin
      add_full = {hi_s[0], lo_s[0]};
      sub_full = {hi_s[1], lo_s[1]};

      // Default: hold results; only out_valid tracks in_valid every cycle.
      sum_d     = sum_q;
      sub_d     = sub_q;
      carry_d   = carry_q;
      borrow_d  = borrow_q;
      add_ovf_d = add_ovf_q;
      sub_ovf_d = sub_ovf_q;
      valid_d   = in_valid;

      if (in_valid) begin
         sum_d     = add_full;
         sub_d     = sub_full;
         carry_d   = hi_c[0];
         // A set carry from a + ~b + 1 means no borrow was needed.
         borrow_d  = ~hi_c[1];
         add_ovf_d = (a_in[MSB] == b_in[MSB]) && (add_full[MSB] != a_in[MSB]);
         sub_ovf_d = (a_in[MSB] != b_in[MSB]) && (sub_full[MSB] != a_in[MSB]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q     <= '0;
         sub_q     <= '0;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         add_ovf_q <= 1'b0;
         sub_ovf_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         sub_q     <= sub_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         add_ovf_q <= add_ovf_d;
         sub_ovf_q <= sub_ovf_d;
         valid_q   <= valid_d;
      end
   end

   assign sum        = sum_q;
   assign sub        = sub_q;
   assign carry_out  = carry_q;
   assign borrow_out = borrow_q;
   assign add_ovf    = add_ovf_q;
   assign sub_ovf    = sub_ovf_q;
   assign out_valid  = valid_q;

endmodule : dsp_addsub

// File: tb/tb_dsp_addsub.sv
// tb_dsp_addsub
//   Directed table vectors, hand-written reset/pipeline/hold sequences and a
//   randomized run against an arithmetic reference model.
module tb_dsp_addsub;

   localparam int W = 32;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] sum;
      logic [W-1:0] sub;
      logic         c;
      logic         bo;
      logic         ao;
      logic         so;
   } out_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      out_t         exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [W-1:0] sum;
   logic [W-1:0] sub;
   logic         carry_out;
   logic         borrow_out;
   logic         add_ovf;
   logic         sub_ovf;
   logic         out_valid;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dsp_addsub #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .a_in       (a_in),
      .b_in       (b_in),
      .sum        (sum),
      .sub        (sub),
      .carry_out  (carry_out),
      .borrow_out (borrow_out),
      .add_ovf    (add_ovf),
      .sub_ovf    (sub_ovf),
      .out_valid  (out_valid)
   );

   // Reference: plain wide/signed arithmetic, no MSB flag equations.
   function automatic out_t ref_calc(input logic [W-1:0] a, input logic [W-1:0] b);
      out_t r;
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint unsigned us = ua + ub;
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          ss = sa + sb;
      longint          sd = sa - sb;
      longint          smax = (64'sd1 <<< (W - 1)) - 1;
      longint          smin = -(64'sd1 <<< (W - 1));
      r.valid = 1'b1;
      r.sum   = us[W-1:0];
      r.c     = us[W];
      r.sub   = a - b;
      r.bo    = (ua < ub);
      r.ao    = (ss > smax) || (ss < smin);
      r.so    = (sd > smax) || (sd < smin);
      return r;
   endfunction

   function automatic out_t mk(input logic v, input logic [W-1:0] s, input logic [W-1:0] d,
                               input logic c, input logic bo, input logic ao, input logic so);
      out_t r;
      r.valid = v; r.sum = s; r.sub = d; r.c = c; r.bo = bo; r.ao = ao; r.so = so;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t exp);
      out_t got;
      got = {out_valid, sum, sub, carry_out, borrow_out, add_ovf, sub_ovf};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got v=%0b sum=%h sub=%h c=%0b b=%0b ao=%0b so=%0b, want v=%0b sum=%h sub=%h c=%0b b=%0b ao=%0b so=%0b",
                  name, got.valid, got.sum, got.sub, got.c, got.bo, got.ao, got.so,
                  exp.valid, exp.sum, exp.sub, exp.c, exp.bo, exp.ao, exp.so);
      end else begin
         $display("ok   %s: v=%0b sum=%h sub=%h c=%0b b=%0b ao=%0b so=%0b",
                  name, got.valid, got.sum, got.sub, got.c, got.bo, got.ao, got.so);
      end
   endtask

   vec_t tbl [9];
   out_t model;
   out_t zero_out;

   initial begin
      zero_out = '0;

      tbl[0] = '{32'h0000FFFF, 32'h00000001, mk(1, 32'h00010000, 32'h0000FFFE, 0, 0, 0, 0)};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000001, mk(1, 32'h00000000, 32'hFFFFFFFE, 1, 0, 0, 0)};
      tbl[2] = '{32'h00000000, 32'h00000001, mk(1, 32'h00000001, 32'hFFFFFFFF, 0, 1, 0, 0)};
      tbl[3] = '{32'h7FFFFFFF, 32'h00000001, mk(1, 32'h80000000, 32'h7FFFFFFE, 0, 0, 1, 0)};
      tbl[4] = '{32'h80000000, 32'h00000001, mk(1, 32'h80000001, 32'h7FFFFFFF, 0, 0, 0, 1)};
      tbl[5] = '{32'h80000000, 32'h80000000, mk(1, 32'h00000000, 32'h00000000, 1, 0, 1, 0)};
      tbl[6] = '{32'h00000005, 32'h00000000, mk(1, 32'h00000005, 32'h00000005, 0, 0, 0, 0)};
      tbl[7] = '{32'h00000003, 32'h00000005, mk(1, 32'h00000008, 32'hFFFFFFFE, 0, 1, 0, 0)};
      tbl[8] = '{32'h80000000, 32'h7FFFFFFF, mk(1, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 1)};

      // Reset held for two edges with a valid operand pair on the inputs.
      reset = 1'b1; in_valid = 1'b1; a_in = 32'd5; b_in = 32'd3;
      step(); check("reset_cyc0", zero_out);
      step(); check("reset_cyc1", zero_out);
      reset = 1'b0;
      step(); check("reset_release", mk(1, 32'd8, 32'd2, 0, 0, 0, 0));

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         a_in = tbl[i].a; b_in = tbl[i].b; in_valid = 1'b1;
         step();
         check($sformatf("tbl%0d a=%h b=%h", i, tbl[i].a, tbl[i].b), tbl[i].exp);
      end

      // Back-to-back issue, then idle cycles hold the last result.
      a_in = 32'd1;  b_in = 32'd2; step(); check("pipe0", mk(1, 32'd3,  32'hFFFFFFFF, 0, 1, 0, 0));
      a_in = 32'd10; b_in = 32'd3; step(); check("pipe1", mk(1, 32'd13, 32'd7,        0, 0, 0, 0));
      a_in = 32'd7;  b_in = 32'd7; step(); check("pipe2", mk(1, 32'd14, 32'd0,        0, 0, 0, 0));
      in_valid = 1'b0; a_in = 32'hDEADBEEF; b_in = 32'h12345678;
      step(); check("hold0", mk(0, 32'd14, 32'd0, 0, 0, 0, 0));
      step(); check("hold1", mk(0, 32'd14, 32'd0, 0, 0, 0, 0));

      // Mid-stream reset discards the in-flight result.
      in_valid = 1'b1; a_in = 32'd100; b_in = 32'd1; reset = 1'b1;
      step(); check("midreset", zero_out);
      reset = 1'b0; in_valid = 1'b0;
      step(); check("midreset_idle", zero_out);

      // Randomized run; model holds its last result like the spec's idle rule.
      model = zero_out;
      for (int i = 0; i < 10000; i++) begin
         logic r;
         r        = ($urandom_range(0, 49) == 0);
         reset    = r;
         in_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       a_in = 32'h80000000;
            1:       a_in = 32'h7FFFFFFF;
            2:       a_in = 32'hFFFFFFFF;
            default: a_in = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b_in = 32'h00000000;
            1:       b_in = 32'h80000000;
            2:       b_in = a_in;
            default: b_in = $urandom;
         endcase
         if (r) begin
            model = zero_out;
         end else if (in_valid) begin
            model = ref_calc(a_in, b_in);
         end else begin
            model.valid = 1'b0;
         end
         step();
         check($sformatf("rand%0d rst=%0b iv=%0b a=%h b=%h", i, r, in_valid, a_in, b_in), model);
      end

      reset = 1'b0; in_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dsp_addsub
